traffic_sensor_conditioner: RTL and testbench

Upstream front end of the traffic light controller FSM. Cleans the three raw vehicle-loop detector inputs and drives the FSM's sensor inputs `S1`, `S2`, `S3`:
- 2-flop synchronization per channel.
- Per-channel debounce.
- Stuck-sensor detection with a failsafe "vehicle present" override.
- Optional request latching, cleared when the served direction turns green.

---
 rtl/traffic_sensor_conditioner.sv | 159 +++++++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
// Front end for the traffic light FSM. Each of the three vehicle-loop inputs
// is synchronized (2 flops), debounced and watched for a stuck-high detector.
// A stuck channel forces its sensor output to "vehicle present".
// Build option: define SENSOR_LATCH_EN to hold a request until the channel's
// light (L1..L3) turns green. Without it, L1..L3 are ignored.

module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 255
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RawS1,
    input  logic       RawS2,
    input  logic       RawS3,
    input  logic [1:0] L1,
    input  logic [1:0] L2,
    input  logic [1:0] L3,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [2:0] Fault
);

    localparam logic [7:0]  DCNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] SCNT_MAX  = 16'(STUCK_CYCLES);

    logic [2:0]  w_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_stable;
    logic [2:0]  w_stable_nxt;
    logic [2:0]  r_fault;
    logic [2:0]  w_demand;
    logic [2:0]  r_sout;
    logic [7:0]  r_dcnt [3];
    logic [15:0] r_scnt [3];

    assign w_raw = {RawS3, RawS2, RawS1};

    // Two-flop synchronizer; only r_sync2 is used downstream
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Next debounced level: flips once sync2 has disagreed for DEBOUNCE_CYCLES edges
    always_comb begin
        w_stable_nxt = r_stable;
        for (int i = 0; i < 3; i++) begin
            if ((r_sync2[i] != r_stable[i]) && (r_dcnt[i] == DCNT_LAST)) begin
                w_stable_nxt[i] = r_sync2[i];
            end
        end
    end

    // Debounce state: any agreement restarts the disagreement run
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_stable <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dcnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stable_nxt;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DCNT_LAST) begin
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 8'd1;
                end
            end
        end
    end

    // Stuck counter: counts debounced-high cycles, saturates, and is zeroed on
    // the same edge the debounced level drops so the fault releases one edge later
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) begin
                r_scnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!w_stable_nxt[i]) begin
                    r_scnt[i] <= '0;
                end else if (r_stable[i] && (r_scnt[i] != SCNT_MAX)) begin
                    r_scnt[i] <= r_scnt[i] + 16'd1;
                end
            end
        end
    end

    // Fault flag: registered compare against the saturation value
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fault <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_fault[i] <= (r_scnt[i] == SCNT_MAX);
            end
        end
    end

`ifdef SENSOR_LATCH_EN
    logic [1:0] w_light [3];
    logic [2:0] r_req;

    assign w_light[0] = L1;
    assign w_light[1] = L2;
    assign w_light[2] = L3;

    // Request flag: set while a vehicle is present, cleared when its light is green
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_req <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_stable[i]) begin
                    r_req[i] <= 1'b1;
                end else if (w_light[i] == 2'b01) begin
                    r_req[i] <= 1'b0;
                end
            end
        end
    end

    // stable is ORed in so the request stage adds no assert latency
    assign w_demand = r_stable | r_req;
`else
    logic w_unused_lights;

    assign w_unused_lights = ^{L1, L2, L3};
    assign w_demand        = r_stable;
`endif

    // Output register: demand or failsafe override
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sout <= '0;
        end else begin
            r_sout <= w_demand | r_fault;
        end
    end

    assign S1    = r_sout[0];
    assign S2    = r_sout[1];
    assign S3    = r_sout[2];
    assign Fault = r_fault;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed latency/glitch/fault/reset
// checks plus randomized pulses against a windowed reference model.

module tb_traffic_sensor_conditioner;

    localparam int DEB = 4;
    localparam int STK = 20;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       RawS1 = 1'b0;
    logic       RawS2 = 1'b0;
    logic       RawS3 = 1'b0;
    logic [1:0] L1 = 2'b11;
    logic [1:0] L2 = 2'b11;
    logic [1:0] L3 = 2'b11;
    logic       S1;
    logic       S2;
    logic       S3;
    logic [2:0] Fault;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .STUCK_CYCLES   (STK)
    ) u_dut (
        .Clock(Clock),
        .Reset(Reset),
        .RawS1(RawS1),
        .RawS2(RawS2),
        .RawS3(RawS3),
        .L1   (L1),
        .L2   (L2),
        .L3   (L3),
        .S1   (S1),
        .S2   (S2),
        .S3   (S3),
        .Fault(Fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A channel's debounced level flips when the last DEB synchronized samples
    // (raw delayed by two edges) all disagree with it. The fault is set once
    // the level has been high for more than STK edges.
    bit m_hist [3][$];
    bit m_stable [3];
    bit m_fault [3];
    bit m_req [3];
    bit m_s [3];
    int m_run [3];

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_hist[c].delete();
            for (int k = 0; k < DEB + 2; k++) m_hist[c].push_back(1'b0);
            m_stable[c] = 0;
            m_fault[c]  = 0;
            m_req[c]    = 0;
            m_s[c]      = 0;
            m_run[c]    = 0;
        end
    endfunction

    function automatic void model_step();
        bit         raw [3];
        logic [1:0] lt [3];
        raw[0] = RawS1; raw[1] = RawS2; raw[2] = RawS3;
        lt[0]  = L1;    lt[1]  = L2;    lt[2]  = L3;
        for (int c = 0; c < 3; c++) begin
            int sz;
            bit all_diff;
            bit n_stable;
            bit n_fault;
            sz = m_hist[c].size();
            all_diff = 1;
            for (int j = 2; j <= DEB + 1; j++) begin
                if (m_hist[c][sz - j] == m_stable[c]) all_diff = 0;
            end
            n_stable = all_diff ? !m_stable[c] : m_stable[c];
            n_fault  = m_stable[c] && (m_run[c] >= STK + 1);
`ifdef SENSOR_LATCH_EN
            m_s[c]   = m_stable[c] | m_req[c] | m_fault[c];
            m_req[c] = m_stable[c] ? 1'b1 : ((lt[c] == 2'b01) ? 1'b0 : m_req[c]);
`else
            m_s[c]   = m_stable[c] | m_fault[c];
`endif
            m_run[c]    = n_stable ? ((m_run[c] < 100000) ? m_run[c] + 1 : m_run[c]) : 0;
            m_stable[c] = n_stable;
            m_fault[c]  = n_fault;
            m_hist[c].push_back(raw[c]);
            if (m_hist[c].size() > DEB + 4) void'(m_hist[c].pop_front());
        end
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) model_reset();
        else       model_step();
    end

    // Continuous comparison against the model on the falling edge
    always @(negedge Clock) begin
        chk("s_vs_model", {29'd0, S3, S2, S1}, {29'd0, m_s[2], m_s[1], m_s[0]});
        chk("fault_vs_model", {29'd0, Fault}, {29'd0, m_fault[2], m_fault[1], m_fault[0]});
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int sel);
        case (sel)
            0:       return S1;
            1:       return S2;
            2:       return S3;
            3:       return Fault[0];
            4:       return Fault[1];
            default: return Fault[2];
        endcase
    endfunction

    // Edges until the selected signal equals val (-1 on timeout)
    task automatic wait_for(input int sel, input logic val, input int maxe, output int e);
        e = -1;
        for (int i = 1; i <= maxe && e < 0; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (sig(sel) === val) e = i;
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        int e;
        int cnt;
        int rise;
        int frise;
        int drop;
        int rem [3];

        // 1: reset and clean assert / deassert
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        chk("reset_s", {29'd0, S3, S2, S1}, 32'd0);
        chk("reset_fault", {29'd0, Fault}, 32'd0);
        RawS1 = 1'b1;
        wait_for(0, 1'b1, 20, e);
        chk("s1_assert_latency", e, 7);
        RawS1 = 1'b0;
`ifndef SENSOR_LATCH_EN
        wait_for(0, 1'b0, 20, e);
        chk("s1_deassert_latency", e, 7);
`else
        edges(12);
`endif

        // 2: glitch rejection and 5-cycle pulse
        RawS2 = 1'b1;
        edges(3);
        RawS2 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge Clock);
            if (S2) cnt++;
        end
        chk("s2_glitch_rejected", cnt, 0);
        RawS2 = 1'b1;
        edges(5);
        RawS2 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (S2) cnt++;
        end
`ifndef SENSOR_LATCH_EN
        chk("s2_pulse_width", cnt, 5);
`endif

        // 3: stuck fault on channel 3
        RawS3 = 1'b1;
        rise = -1; frise = -1; drop = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clock);
            if (S3 && rise < 0) rise = i;
            if (Fault[2] && frise < 0) frise = i;
            if (rise > 0 && !S3) drop = 1;
        end
        chk("s3_assert_latency", rise, 7);
        chk("fault3_rise_edge", frise, 27);
        chk("s3_held_during_fault", drop, 0);
        RawS3 = 1'b0;
        rise = -1; frise = -1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge Clock);
            if (!Fault[2] && frise < 0) frise = i;
            if (!S3 && rise < 0) rise = i;
        end
        chk("fault3_clear_edge", frise, 7);
`ifndef SENSOR_LATCH_EN
        chk("s3_fall_edge", rise, 8);
`endif

`ifdef SENSOR_LATCH_EN
        // 4: request latching
        L1 = 2'b01; L2 = 2'b01; L3 = 2'b01;
        edges(12);
        L1 = 2'b11; L2 = 2'b11; L3 = 2'b11;
        chk("s1_cleared_before_latch", {31'd0, S1}, 32'd0);
        RawS1 = 1'b1;
        edges(6);
        RawS1 = 1'b0;
        edges(15);
        chk("s1_latched", {31'd0, S1}, 32'd1);
        L1 = 2'b01;
        wait_for(0, 1'b0, 10, e);
        chk("s1_green_clear_latency", e, 2);
        L1 = 2'b11;
        RawS1 = 1'b1;
        edges(12);
        L1 = 2'b01;
        edges(10);
        chk("s1_held_while_green", {31'd0, S1}, 32'd1);
        RawS1 = 1'b0;
        edges(15);
        chk("s1_released_on_green", {31'd0, S1}, 32'd0);
        L1 = 2'b11;
`endif

        // 5: asynchronous reset in the middle of a debounce run
        RawS2 = 1'b1;
        edges(10);
        chk("s2_high_before_reset", {31'd0, S2}, 32'd1);
        RawS1 = 1'b1;
        edges(4);
        #2 Reset = 1'b1;
        #1;
        chk("async_reset_s", {29'd0, S3, S2, S1}, 32'd0);
        chk("async_reset_fault", {29'd0, Fault}, 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        wait_for(0, 1'b1, 20, e);
        chk("s1_latency_after_reset", e, 7);
        RawS1 = 1'b0;
        RawS2 = 1'b0;
        edges(20);

        // 6: independent random pulses on all channels
        for (int c = 0; c < 3; c++) rem[c] = $urandom_range(1, 10);
        for (int t = 0; t < 5000; t++) begin
            @(negedge Clock);
            for (int c = 0; c < 3; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    rem[c] = $urandom_range(1, 10);
                    case (c)
                        0:       RawS1 = ~RawS1;
                        1:       RawS2 = ~RawS2;
                        default: RawS3 = ~RawS3;
                    endcase
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                L1 = 2'($urandom_range(1, 3));
                L2 = 2'($urandom_range(1, 3));
                L3 = 2'($urandom_range(1, 3));
            end
        end
        RawS1 = 1'b0; RawS2 = 1'b0; RawS3 = 1'b0;
        edges(30);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
